// File: rtl/overlap_accum_seq.sv
// Four-beat overlapped accumulator: P1/P4 land on even bits (P4 shifted up by one
// lane), P2/P3 on odd bits; the result is held until downstream takes it.

module overlap_accum_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       take,
  input  logic [1:0] idx,
  input  logic       d,
  input  logic       d_prev,
  output logic [1:0] bits
);
  // bits[0] is ACC[2i] (P1[i] ^ P4[i-1]), bits[1] is ACC[2i+1] (P2[i] ^ P3[i])
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      bits <= '0;
    end else if (take) begin
      case (idx)
        2'd0:    bits <= {1'b0, d};
        2'd1,
        2'd2:    bits[1] <= bits[1] ^ d;
        default: bits[0] <= bits[0] ^ d_prev;
      endcase
    end
  end
endmodule

module overlap_accum_seq #(
  parameter int W       = 117,
  parameter bit OUT_REG = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic [1:0]   beat_idx,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [2*W:0] out_data
);
  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  state_t               state, state_nx;
  logic [1:0]           idx, idx_nx;
  logic                 top, top_nx;
  logic                 take;
  logic [W-1:0]         d_ext;
  logic [W-1:0][1:0]    lane_bits;
  logic [2*W:0]         acc;

  assign out_valid = (state == HOLD);
  assign in_ready  = !out_valid;
  assign beat_idx  = idx;
  // clr blocks acceptance in its own cycle
  assign take      = in_valid && in_ready && !clr;
  assign d_ext     = {in_data[W-2:0], 1'b0};
  assign acc       = {top, lane_bits};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      top   <= 1'b0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      top   <= top_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    top_nx   = top;
    if (clr) begin
      state_nx = IDLE;
      idx_nx   = '0;
      top_nx   = 1'b0;
    end else begin
      if (take) begin
        idx_nx = idx + 2'd1;
        if (idx == 2'd0) top_nx = 1'b0;
        if (idx == 2'd3) top_nx = in_data[W-1];
      end
      case (state)
        IDLE:    if (take) state_nx = COLLECT;
        COLLECT: if (take && idx == 2'd3) state_nx = HOLD;
        HOLD:    if (out_ready) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < W; i++) begin : g_lane
    overlap_accum_lane u_lane (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .take   (take),
      .idx    (idx),
      .d      (in_data[i]),
      .d_prev (d_ext[i]),
      .bits   (lane_bits[i])
    );
  end

  if (OUT_REG) begin : g_oreg
    logic [2*W:0] p4_spread;
    logic [2*W:0] out_q;

    always_comb begin
      p4_spread = '0;
      for (int i = 0; i < W; i++) p4_spread[2*i+2] = in_data[i];
    end

    // Captures the finished result on the last beat so it appears with out_valid
    always_ff @(posedge clk) begin
      if (rst || clr)                 out_q <= '0;
      else if (take && idx == 2'd3)   out_q <= acc ^ p4_spread;
    end
    assign out_data = out_q;
  end else begin : g_ocomb
    assign out_data = acc;
  end
endmodule

// File: doc/overlap_accum_seq.md
OVERLAP_ACCUM_SEQ -- requirements
Module: overlap_accum_seq

Interface
REQ-001 The block SHALL have parameter W, default 117, the partial-product width in bits (W >= 2).
REQ-002 The block SHALL have parameter OUT_REG, default 1: 1 = registered out_data; 0 = out_data driven from the accumulator with identical timing.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-005 The block SHALL have port clr, input, 1, synchronous abort that discards any partial set.
REQ-006 The block SHALL have port in_valid, input, 1, input beat valid.
REQ-007 The block SHALL have port in_ready, output, 1, block can accept a beat.
REQ-008 The block SHALL have port in_data, input, W, one partial product per beat.
REQ-009 The block SHALL have port beat_idx, output, 2, index (0..3) of the next beat expected.
REQ-010 The block SHALL have port out_valid, output, 1, combined result valid.
REQ-011 The block SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-012 The block SHALL have port out_data, output, 2W+1, combined overlapped result.

Function
REQ-013 A beat SHALL be accepted when in_valid && in_ready at a rising edge; a set is four accepted beats, in order P1, P2, P3, P4 (beat_idx 0,1,2,3).
REQ-014 The result SHALL be, for i in 0..W-1: out[2i] = P1[i] ^ P4[i-1], with P4[-1] = 0; out[2i+1] = P2[i] ^ P3[i]; out[2W] = P4[W-1].
REQ-015 Accumulation SHALL be incremental in a 2W+1-bit register ACC:
- beat 0 loads ACC with P1 spread to even bits and clears all other bits;
- beat 1 XORs P2 into odd bits 2i+1;
- beat 2 XORs P3 into odd bits 2i+1;
- beat 3 XORs P4 into even bits 2i+2.
REQ-016 The FSM SHALL have states IDLE (beat_idx = 0), COLLECT (beat_idx 1..3) and HOLD.
- IDLE -> COLLECT on accepting beat 0.
- COLLECT -> HOLD on accepting beat 3.
- HOLD -> IDLE on out_valid && out_ready.
REQ-017 out_valid SHALL assert exactly one cycle after beat 3 is accepted and stay high, with out_data stable, until out_ready is sampled high.
REQ-018 in_ready SHALL equal !out_valid, so no beat is accepted in HOLD; minimum spacing is 5 cycles per result with out_ready tied high.
REQ-019 In the cycle the result is consumed, in_ready SHALL still be 0; the next set's beat 0 is accepted no earlier than the following cycle.
REQ-020 Idle cycles (in_valid = 0) inside a set SHALL be allowed and SHALL leave ACC and beat_idx unchanged.
REQ-021 beat_idx SHALL wrap 3 -> 0 on acceptance of beat 3.
REQ-022 clr SHALL act in any state:
- return to IDLE, beat_idx = 0, out_valid = 0, ACC = 0;
- a beat presented in the same cycle is not accepted (in_ready treated as 0 for that cycle);
- clr in HOLD drops the pending result.
REQ-023 If rst and clr are both high, rst SHALL take precedence; the resulting state is the same.
REQ-024 Outputs SHALL depend only on registered state, with no combinational path from in_data or out_ready to any output.

Reset
REQ-025 When rst is sampled high, the block SHALL enter IDLE with beat_idx = 0, out_valid = 0, in_ready = 1 (from the next cycle), ACC = 0 and out_data = 0.
REQ-026 Reset asserted mid-set or in HOLD SHALL discard all partial data, and the first beat after reset SHALL be treated as P1.

Verification (W = 4, out 9 bits)
REQ-027 The bench SHALL drive P1 = 4'b0001, P2 = P3 = P4 = 0 back-to-back with out_ready = 1 -> out_valid one cycle after beat 3, out_data = 9'h001.
REQ-028 The bench SHALL drive P1 = 0, P2 = 4'b1111, P3 = 4'b0101, P4 = 0 -> out_data = 9'h088.
REQ-029 The bench SHALL drive P1 = 4'b0001, P2 = P3 = 0, P4 = 4'b1001 -> out_data = 9'h105; it SHALL then drive P4 = 4'b1000 alone (other beats 0) -> out_data = 9'h100.
REQ-030 The bench SHALL hold out_ready = 0 for 3 cycles after out_valid while driving in_valid = 1 -> in_ready = 0, out_data stable; the result is consumed on out_ready = 1 and beat 0 of the next set is accepted the following cycle.
REQ-031 The bench SHALL pulse clr after 2 beats, then send a full set 1,2,4,8 -> the result equals the golden model of that set only, with no residue from the aborted beats.
REQ-032 The bench SHALL assert rst in HOLD and in COLLECT (beat_idx = 2) -> next cycle out_valid = 0, beat_idx = 0, out_data = 0; it SHALL also run a 1000-set random regression at W = 117 against the REQ-014 model with random in_valid/out_ready gaps.
